seg7_scan_driver: RTL and testbench

//  Time-multiplexed 4-digit seven-segment driver for the Basys3 display.

---
 rtl/seg7_scan_driver_pkg.sv | 42 ++++
 rtl/hex_to_seg7.sv | 36 +++
 rtl/seg7_scan_driver.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the seven-segment display blocks.
// Holds the active-low segment patterns ({g,f,e,d,c,b,a}), the all-dark
// segment and anode values, and a helper that turns a digit index into its
// active-low anode select.
package seg7_scan_driver_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;

  localparam seg_t       SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low one-hot anode select for a digit index.
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    logic [3:0] an_v;
    case (idx)
      2'd0:    an_v = 4'b1110;
      2'd1:    an_v = 4'b1101;
      2'd2:    an_v = 4'b1011;
      2'd3:    an_v = 4'b0111;
      default: an_v = AN_OFF;
    endcase
    return an_v;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: purely combinational hex nibble to seven-segment decoder.
// Ports:
//   hex_i  in  4  nibble to display
//   seg_o  out 7  segments {g,f,e,d,c,b,a}, active low
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Nibble to segment pattern lookup.
  always_comb begin
    seg_o = SEG_OFF;
    case (hex_i)
      4'h0:    seg_o = SEG_0;
      4'h1:    seg_o = SEG_1;
      4'h2:    seg_o = SEG_2;
      4'h3:    seg_o = SEG_3;
      4'h4:    seg_o = SEG_4;
      4'h5:    seg_o = SEG_5;
      4'h6:    seg_o = SEG_6;
      4'h7:    seg_o = SEG_7;
      4'h8:    seg_o = SEG_8;
      4'h9:    seg_o = SEG_9;
      4'hA:    seg_o = SEG_A;
      4'hB:    seg_o = SEG_B;
      4'hC:    seg_o = SEG_C;
      4'hD:    seg_o = SEG_D;
      4'hE:    seg_o = SEG_E;
      4'hF:    seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 4-digit seven-segment display driver.
// One digit is lit per refresh slot of DIV = CLK_HZ/REFRESH_HZ cycles; the
// first BLANK_CYC cycles of every slot keep all anodes dark so the previous
// digit's pattern never ghosts onto the next anode. DIV must be at least
// BLANK_CYC+2. Inputs are copied into shadow registers once per frame (four
// slots) so a digit never shows a half-updated value.
// Ports:
//   clk         in  1   system clock
//   rst_n       in  1   synchronous reset, active low
//   value       in  16  four hex nibbles, value[3:0] is the rightmost digit
//   dp_in       in  4   decimal point per digit, active high
//   digit_en    in  4   per-digit enable, 0 keeps that digit dark
//   seg         out 7   segments {g,f,e,d,c,b,a}, active low
//   dp          out 1   decimal point, active low
//   an          out 4   digit anodes, active low, at most one low
//   frame_done  out 1   one-cycle pulse at each frame boundary
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int DIV   = CLK_HZ / REFRESH_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_value_q;
  logic [3:0]       shadow_dp_q;
  logic [3:0]       shadow_en_q;
  // Clear until the first shadow load after reset, so the first frame
  // picks up the inputs immediately instead of a whole frame later.
  logic             loaded_q;

  logic [6:0]       seg_q;
  logic             dp_q;
  logic [3:0]       an_q;
  logic             frame_done_q;

  logic             slot_end_s;
  logic             frame_end_s;
  logic             load_s;
  logic [3:0]       nibble_s;
  logic [6:0]       seg_s;
  logic [3:0]       an_d;
  logic             dp_d;

  assign slot_end_s  = (cnt_q == CNT_LAST);
  assign frame_end_s = slot_end_s && (idx_q == 2'd3);
  assign load_s      = frame_end_s || !loaded_q;

  // Prescaler and digit index next state; idx wraps 3->0 naturally.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (slot_end_s) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
  end

  // Select the shadow nibble of the digit currently being scanned.
  always_comb begin
    nibble_s = 4'h0;
    case (idx_q)
      2'd0:    nibble_s = shadow_value_q[3:0];
      2'd1:    nibble_s = shadow_value_q[7:4];
      2'd2:    nibble_s = shadow_value_q[11:8];
      2'd3:    nibble_s = shadow_value_q[15:12];
      default: nibble_s = 4'h0;
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .hex_i (nibble_s),
    .seg_o (seg_s)
  );

  // Anode and decimal-point next values. Every slot starts blanked, so the
  // anode never moves directly from one digit to another.
  always_comb begin
    an_d = AN_OFF;
    if (cnt_q < CNT_BLANK) begin
      an_d = AN_OFF;
    end else if (shadow_en_q[idx_q]) begin
      an_d = an_select(idx_q);
    end else begin
      an_d = AN_OFF;
    end
    dp_d = ~shadow_dp_q[idx_q];
  end

  // State, shadow and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      idx_q          <= 2'd0;
      shadow_value_q <= 16'h0000;
      shadow_dp_q    <= 4'h0;
      shadow_en_q    <= 4'h0;
      loaded_q       <= 1'b0;
      seg_q          <= SEG_OFF;
      dp_q           <= 1'b1;
      an_q           <= AN_OFF;
      frame_done_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      loaded_q     <= 1'b1;
      if (load_s) begin
        shadow_value_q <= value;
        shadow_dp_q    <= dp_in;
        shadow_en_q    <= digit_en;
      end
      seg_q        <= seg_s;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_end_s;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIV=10, BLANK_CYC=2).
// A reference model pushes the expected pin values for each clock edge into a
// queue; the scenario tasks pop and compare on the falling edge and add
// their own scenario-specific checks.
module tb_seg7_scan_driver;

  localparam int CLK_HZ     = 1000;
  localparam int REFRESH_HZ = 100;
  localparam int BLANK_CYC  = 2;
  localparam int DIV        = CLK_HZ / REFRESH_HZ;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  logic [12:0] exp_q[$];   // {an, seg, dp, frame_done}
  logic [12:0] exp_e;

  int          m_cnt;
  int          m_idx;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_en;
  logic        m_loaded;

  seg7_scan_driver #(
    .CLK_HZ     (CLK_HZ),
    .REFRESH_HZ (REFRESH_HZ),
    .BLANK_CYC  (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] ref_an(input int cnt, input int idx, input logic [3:0] en);
    logic [3:0] a;
    logic [3:0] one;
    one = 4'b0001;
    if (cnt < BLANK_CYC || !en[idx]) a = 4'hF;
    else a = ~(one << idx);
    return a;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] v, input int idx);
    return v[idx*4 +: 4];
  endfunction

  // Reference model: expected pins for this edge come from pre-edge state.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.push_back({4'hF, 7'h7F, 1'b1, 1'b0});
      m_cnt    <= 0;
      m_idx    <= 0;
      m_val    <= 16'h0000;
      m_dp     <= 4'h0;
      m_en     <= 4'h0;
      m_loaded <= 1'b0;
    end else begin
      exp_q.push_back({ref_an(m_cnt, m_idx, m_en), ref_seg(nib(m_val, m_idx)),
                       ~m_dp[m_idx], (m_cnt == DIV-1 && m_idx == 3)});
      if ((m_cnt == DIV-1 && m_idx == 3) || !m_loaded) begin
        m_val <= value;
        m_dp  <= dp_in;
        m_en  <= digit_en;
      end
      m_loaded <= 1'b1;
      m_cnt    <= (m_cnt == DIV-1) ? 0 : m_cnt + 1;
      m_idx    <= (m_cnt == DIV-1) ? (m_idx + 1) % 4 : m_idx;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; value = 16'h0000; dp_in = 4'h0; digit_en = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL reset_sb: no expected entry"); end
      else begin
        exp_e = exp_q[$]; exp_q.delete();
        if ({an, seg, dp, frame_done} !== exp_e) begin
          failures++; $display("FAIL reset_sb: got %h want %h", {an, seg, dp, frame_done}, exp_e);
        end
      end
      checks++;
      if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        failures++; $display("FAIL reset_vals: got %h want %h", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic test_scan();
    int blank_n = 0;
    int lit_n   = 0;
    value = 16'h3210; digit_en = 4'hF; dp_in = 4'h0; rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL scan_sb: no expected entry"); end
      else begin
        exp_e = exp_q[$]; exp_q.delete();
        if ({an, seg, dp, frame_done} !== exp_e) begin
          failures++; $display("FAIL scan_sb: got %h want %h", {an, seg, dp, frame_done}, exp_e);
        end
      end
      if (an === 4'hF) blank_n++;
      else begin
        lit_n++;
        checks++;
        if (!((an === 4'b1110 && seg === 7'b1000000) || (an === 4'b1101 && seg === 7'b1111001) ||
              (an === 4'b1011 && seg === 7'b0100100) || (an === 4'b0111 && seg === 7'b0110000))) begin
          failures++; $display("FAIL scan_digit: an=%b seg=%b", an, seg);
        end
      end
    end
    checks++;
    if (blank_n != 8 || lit_n != 32) begin
      failures++; $display("FAIL scan_blank: blank=%0d lit=%0d want 8/32", blank_n, lit_n);
    end
  endtask

  task automatic test_hold();
    bit seen = 1'b0;
    // Move 15 cycles into the frame, then change the input.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL hold_sb: no expected entry"); end
      else begin
        exp_e = exp_q[$]; exp_q.delete();
        if ({an, seg, dp, frame_done} !== exp_e) begin
          failures++; $display("FAIL hold_sb: got %h want %h", {an, seg, dp, frame_done}, exp_e);
        end
      end
    end
    value = 16'hFFFF;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL hold_sb: no expected entry"); end
      else begin
        exp_e = exp_q[$]; exp_q.delete();
        if ({an, seg, dp, frame_done} !== exp_e) begin
          failures++; $display("FAIL hold_sb: got %h want %h", {an, seg, dp, frame_done}, exp_e);
        end
      end
      checks++;
      if (an !== 4'hF && seg === 7'b0001110) begin
        failures++; $display("FAIL hold_early: an=%b seg=%b want old digit", an, seg);
      end
      seen = frame_done;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL hold_timeout: frame_done=0 want 1"); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL hold_sb: no expected entry"); end
      else begin
        exp_e = exp_q[$]; exp_q.delete();
        if ({an, seg, dp, frame_done} !== exp_e) begin
          failures++; $display("FAIL hold_sb: got %h want %h", {an, seg, dp, frame_done}, exp_e);
        end
      end
      checks++;
      if (frame_done !== (i == 39)) begin
        failures++; $display("FAIL hold_period: cycle %0d frame_done=%b want %b", i, frame_done, (i == 39));
      end
      checks++;
      if (seg !== 7'b0001110) begin
        failures++; $display("FAIL hold_new: seg=%b want 0001110", seg);
      end
    end
  endtask

  task automatic test_enable();
    int dp_low = 0;
    int d0_n   = 0;
    int d2_n   = 0;
    digit_en = 4'b0101; dp_in = 4'b0001; value = 16'h3210;
    // Previous task ends on the frame boundary; run one full frame to load.
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL enable_sb: no expected entry"); end
      else begin
        exp_e = exp_q[$]; exp_q.delete();
        if ({an, seg, dp, frame_done} !== exp_e) begin
          failures++; $display("FAIL enable_sb: got %h want %h", {an, seg, dp, frame_done}, exp_e);
        end
      end
      if (i >= 40) begin
        checks++;
        if (an[1] !== 1'b1 || an[3] !== 1'b1) begin
          failures++; $display("FAIL enable_dark: an=%b want an[1]=an[3]=1", an);
        end
        if (dp === 1'b0) dp_low++;
        if (an === 4'b1110) d0_n++;
        if (an === 4'b1011) d2_n++;
        if (an === 4'b1110) begin
          checks++;
          if (dp !== 1'b0) begin failures++; $display("FAIL enable_dp0: dp=%b want 0", dp); end
        end
      end
    end
    checks++;
    if (dp_low != 10 || d0_n != 8 || d2_n != 8) begin
      failures++; $display("FAIL enable_counts: dp_low=%0d d0=%0d d2=%0d want 10/8/8", dp_low, d0_n, d2_n);
    end
  endtask

  task automatic test_midreset();
    bit hit   = 1'b0;
    int first = 0;
    digit_en = 4'hF; dp_in = 4'h0; value = 16'h3210;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL midrst_sb: no expected entry"); end
      else begin
        exp_e = exp_q[$]; exp_q.delete();
        if ({an, seg, dp, frame_done} !== exp_e) begin
          failures++; $display("FAIL midrst_sb: got %h want %h", {an, seg, dp, frame_done}, exp_e);
        end
      end
      hit = (i > 40) && (an === 4'b1011);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL midrst_timeout: an never 1011"); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++; $display("FAIL midrst_vals: got %h want %h", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    if (exp_q.size() != 0) exp_q.delete();
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL midrst_sb: no expected entry"); end
      else begin
        exp_e = exp_q[$]; exp_q.delete();
        if ({an, seg, dp, frame_done} !== exp_e) begin
          failures++; $display("FAIL midrst_sb: got %h want %h", {an, seg, dp, frame_done}, exp_e);
        end
      end
      if (first == 0 && an !== 4'hF) begin
        first = k;
        checks++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
          failures++; $display("FAIL midrst_digit: an=%b seg=%b want 1110/1000000", an, seg);
        end
      end
    end
    checks++;
    if (first != 3) begin failures++; $display("FAIL midrst_restart: first lit cycle %0d want 3", first); end
  endtask

  task automatic test_adder();
    logic a, b, cin;
    logic [1:0] s;
    bit fd, lit;
    digit_en = 4'h1; dp_in = 4'h0;
    for (int sw = 0; sw < 8; sw++) begin
      a = sw[2]; b = sw[1]; cin = sw[0];
      s = {1'b0, a} + {1'b0, b} + {1'b0, cin};
      value = {3'b000, a, 3'b000, b, 3'b000, cin, 2'b00, s};
      fd = 1'b0; lit = 1'b0;
      for (int i = 0; i < 90 && !lit; i++) begin
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL adder_sb: no expected entry"); end
        else begin
          exp_e = exp_q[$]; exp_q.delete();
          if ({an, seg, dp, frame_done} !== exp_e) begin
            failures++; $display("FAIL adder_sb: got %h want %h", {an, seg, dp, frame_done}, exp_e);
          end
        end
        if (fd && an === 4'b1110) begin
          lit = 1'b1;
          checks++;
          if (seg !== ref_seg({2'b00, s})) begin
            failures++; $display("FAIL adder_sum: sw=%0d seg=%b want %b", sw, seg, ref_seg({2'b00, s}));
          end
        end
        if (frame_done) fd = 1'b1;
      end
      checks++;
      if (!lit) begin failures++; $display("FAIL adder_timeout: sw=%0d digit 0 never lit", sw); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_hold();
    test_enable();
    test_midreset();
    test_adder();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
